vram_arbiter: RTL and testbench

Arbiter and sequencer for the Sord M5's single-port 16 KiB video RAM, shared by three requesters:
- VDP display fetch (video);
- ROM/cartridge download loader;
- Z80 CPU VDP-port path.

It grants at most one RAM access per `clk` cycle with fixed priority plus a CPU anti-starvation override, and routes read data back to the owner one cycle later. It sits inside `sordM5` between the video generator, the loader and the CPU bus logic, directly in front of the VRAM block.

---
 rtl/sordm5_pkg.sv | 14 +
 rtl/vram_starve_ctr.sv | 27 ++
 rtl/vram_arbiter.sv | 112 +++++++++++
 tb/tb_vram_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sordm5_pkg.sv
// Shared Sord M5 definitions: VRAM geometry and the arbiter owner encoding.
package sordm5_pkg;

   localparam int unsigned VRAM_ADDR_W = 14;
   localparam int unsigned VRAM_DATA_W = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_LD   = 2'd2,
      OWN_CPU  = 2'd3
   } owner_e;

endpackage

// File: rtl/vram_starve_ctr.sv
// Saturating count of cycles the CPU has waited with a pending request.
module vram_starve_ctr #(
   parameter int unsigned MAX = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic ack,
   output logic starved_c
);

   localparam int unsigned CNT_W = $clog2(MAX + 1);

   logic [CNT_W-1:0] cnt;

   // Count only while waiting; any ack or dropped request restarts the wait.
   always_ff @(posedge clk) begin
      if (reset || !req || ack) begin
         cnt <= '0;
      end else if (cnt != CNT_W'(MAX)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign starved_c = (cnt >= CNT_W'(MAX));

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video > starved CPU > loader > CPU, one access per cycle,
// read data returned to the owner one cycle after the grant.
module vram_arbiter
   import sordm5_pkg::*;
#(
   parameter int unsigned ADDR_W     = VRAM_ADDR_W,
   parameter int unsigned DATA_W     = VRAM_DATA_W,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_data,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ack,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_din,
   output logic              cpu_ack,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_dout,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_q,
   output logic [1:0]        owner
);

   owner_e            grant;
   owner_e            tag_q;
   logic              cpu_starved_c;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;

   vram_starve_ctr #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clk       (clk),
      .reset     (reset),
      .req       (cpu_req),
      .ack       (cpu_ack),
      .starved_c (cpu_starved_c)
   );

   // Priority decision; reset suppresses every grant.
   always_comb begin
      grant = OWN_NONE;
      if (!reset) begin
         if (vid_req)                       grant = OWN_VID;
         else if (cpu_req && cpu_starved_c) grant = OWN_CPU;
         else if (ld_req)                   grant = OWN_LD;
         else if (cpu_req)                  grant = OWN_CPU;
      end
   end

   // RAM port mux; idle cycles keep the previous address and data on the bus.
   always_comb begin
      ram_addr = addr_q;
      ram_din  = din_q;
      ram_we   = 1'b0;
      unique case (grant)
         OWN_VID: ram_addr = vid_addr;
         OWN_LD: begin
            ram_addr = ld_addr;
            ram_din  = ld_data;
            ram_we   = 1'b1;
         end
         OWN_CPU: begin
            ram_addr = cpu_addr;
            ram_din  = cpu_din;
            ram_we   = cpu_we;
         end
         default: ;
      endcase
      if (reset) begin
         ram_addr = '0;
         ram_din  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         din_q  <= '0;
         tag_q  <= OWN_NONE;
      end else begin
         addr_q <= ram_addr;
         din_q  <= ram_din;
         if (grant == OWN_VID)                  tag_q <= OWN_VID;
         else if (grant == OWN_CPU && !cpu_we)  tag_q <= OWN_CPU;
         else                                   tag_q <= OWN_NONE;
      end
   end

   assign vid_ack    = (grant == OWN_VID);
   assign ld_ack     = (grant == OWN_LD);
   assign cpu_ack    = (grant == OWN_CPU);
   assign owner      = grant;

   // A read in flight when reset arrives never reports back.
   assign vid_rvalid = !reset && (tag_q == OWN_VID);
   assign cpu_rvalid = !reset && (tag_q == OWN_CPU);
   assign vid_data   = ram_q;
   assign cpu_dout   = ram_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural 16 KiB sync RAM.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        vid_req, vid_ack, vid_rvalid;
   logic [13:0] vid_addr;
   logic [7:0]  vid_data;
   logic        ld_req, ld_ack;
   logic [13:0] ld_addr;
   logic [7:0]  ld_data;
   logic        cpu_req, cpu_we, cpu_ack, cpu_rvalid;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_din, cpu_dout;
   logic [13:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_din, ram_q;
   logic [1:0]  owner;

   logic [7:0]  mem [0:16383];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_q <= mem[ram_addr];
   end

   vram_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .vid_req    (vid_req),
      .vid_addr   (vid_addr),
      .vid_ack    (vid_ack),
      .vid_rvalid (vid_rvalid),
      .vid_data   (vid_data),
      .ld_req     (ld_req),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .ld_ack     (ld_ack),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_din    (cpu_din),
      .cpu_ack    (cpu_ack),
      .cpu_rvalid (cpu_rvalid),
      .cpu_dout   (cpu_dout),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_din    (ram_din),
      .ram_q      (ram_q),
      .owner      (owner)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle();
      vid_req = 1'b0;
      ld_req  = 1'b0;
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
   endtask

   logic [1:0] pri_exp [10] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd3};

   initial begin
      // Reset with every requester asking
      reset    = 1'b1;
      vid_req  = 1'b1; vid_addr = 14'h0042;
      ld_req   = 1'b1; ld_addr  = 14'h0000; ld_data = 8'h00;
      cpu_req  = 1'b1; cpu_we   = 1'b0; cpu_addr = 14'h0000; cpu_din = 8'h00;
      repeat (2) next_cycle();
      sample();
      check("rst_vid_ack", vid_ack, 0);
      check("rst_ld_ack", ld_ack, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_vid_rvalid", vid_rvalid, 0);
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_owner", owner, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_din, 0);

      next_cycle(); reset = 1'b0;
      sample();
      check("post_rst_vid_ack", vid_ack, 1);
      check("post_rst_ld_ack", ld_ack, 0);
      check("post_rst_cpu_ack", cpu_ack, 0);
      check("post_rst_owner", owner, 1);
      check("post_rst_ram_addr", ram_addr, 14'h0042);
      check("post_rst_ram_we", ram_we, 0);

      next_cycle(); idle();
      sample();
      check("post_rst_vid_rvalid", vid_rvalid, 1);
      check("idle_owner", owner, 0);
      check("idle_ram_addr_hold", ram_addr, 14'h0042);

      // Loader preload, back-to-back writes
      next_cycle(); ld_req = 1'b1; ld_addr = 14'h1234; ld_data = 8'hA5;
      sample();
      check("ld0_ack", ld_ack, 1);
      check("ld0_we", ram_we, 1);
      check("ld0_addr", ram_addr, 14'h1234);
      check("ld0_din", ram_din, 8'hA5);
      check("ld0_owner", owner, 2);
      next_cycle(); ld_addr = 14'h0100; ld_data = 8'h3C;
      sample();
      check("ld1_ack", ld_ack, 1);
      check("ld1_addr", ram_addr, 14'h0100);
      next_cycle(); idle();
      sample();
      check("ld_idle_we", ram_we, 0);

      // Video read of preloaded word
      next_cycle(); vid_req = 1'b1; vid_addr = 14'h1234;
      sample();
      check("vrd_ack", vid_ack, 1);
      next_cycle(); idle();
      sample();
      check("vrd_rvalid", vid_rvalid, 1);
      check("vrd_data", vid_data, 8'hA5);
      check("vrd_cpu_rvalid", cpu_rvalid, 0);
      next_cycle();
      sample();
      check("vrd_rvalid_pulse", vid_rvalid, 0);

      // Priority: alternating video, loader and CPU read always pending
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         vid_req  = (i % 2 == 0);
         ld_req   = 1'b1; ld_addr = 14'h2000 + 14'(i); ld_data = 8'(i);
         cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr = 14'h0100;
         sample();
         check($sformatf("pri_owner_%0d", i), owner, pri_exp[i]);
         check($sformatf("pri_cpu_ack_%0d", i), cpu_ack, (i == 9));
      end
      next_cycle(); idle();
      sample();
      check("pri_cpu_rvalid", cpu_rvalid, 1);
      check("pri_cpu_dout", cpu_dout, 8'h3C);
      check("pri_vid_rvalid", vid_rvalid, 0);

      // Starvation: loader held, CPU waits exactly STARVE_MAX cycles
      for (int i = 0; i < 9; i++) begin
         next_cycle();
         ld_req  = 1'b1; ld_addr = 14'h2100; ld_data = 8'h11;
         cpu_req = 1'b1; cpu_we  = 1'b0; cpu_addr = 14'h1234;
         sample();
         check($sformatf("stv_ld_ack_%0d", i), ld_ack, (i < 8));
         check($sformatf("stv_cpu_ack_%0d", i), cpu_ack, (i == 8));
      end
      next_cycle();
      sample();
      check("stv_cleared_ld_ack", ld_ack, 1);
      check("stv_cleared_cpu_ack", cpu_ack, 0);
      check("stv_cpu_rvalid", cpu_rvalid, 1);
      check("stv_cpu_dout", cpu_dout, 8'hA5);
      next_cycle(); idle();
      sample();

      // CPU write then read of the top address
      next_cycle(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_din = 8'h5A;
      sample();
      check("cwr_ack", cpu_ack, 1);
      check("cwr_we", ram_we, 1);
      check("cwr_addr", ram_addr, 14'h3FFF);
      check("cwr_din", ram_din, 8'h5A);
      next_cycle(); cpu_we = 1'b0;
      sample();
      check("crd_ack", cpu_ack, 1);
      check("crd_we", ram_we, 0);
      check("crd_no_rvalid_after_wr", cpu_rvalid, 0);
      next_cycle(); idle();
      sample();
      check("crd_rvalid", cpu_rvalid, 1);
      check("crd_dout", cpu_dout, 8'h5A);
      check("crd_idle_addr", ram_addr, 14'h3FFF);

      // Reset arriving while a CPU read is in flight
      next_cycle(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0100;
      sample();
      check("mrst_ack", cpu_ack, 1);
      next_cycle(); reset = 1'b1; vid_req = 1'b1;
      sample();
      check("mrst_cpu_rvalid", cpu_rvalid, 0);
      check("mrst_cpu_ack", cpu_ack, 0);
      check("mrst_vid_ack", vid_ack, 0);
      check("mrst_owner", owner, 0);
      check("mrst_ram_addr", ram_addr, 0);
      check("mrst_ram_din", ram_din, 0);
      check("mrst_ram_we", ram_we, 0);
      next_cycle(); reset = 1'b0; idle();
      sample();
      check("mrst_after_cpu_rvalid", cpu_rvalid, 0);
      check("mrst_after_vid_rvalid", vid_rvalid, 0);
      check("mrst_after_ram_addr", ram_addr, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
